// File: rtl/axi_lite_regfile_if.sv
// rtl/axi_lite_regfile_if.sv - AXI4-Lite bundle, 32-bit address and data
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport s (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite register bank with RW control and RO status registers
module axi_lite_regfile #(
  parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
  parameter int                   N_RW      = 8,
  parameter int                   N_RO      = 8,
  parameter logic [N_RW*32-1:0]   RW_RESET  = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi4_lite_if.s                  axi,
  output logic [N_RW*32-1:0]      ctrl_o,
  input  logic [N_RO*32-1:0]      status_i,
  output logic [N_RW-1:0]         wr_stb_o,
  output logic [N_RW+N_RO-1:0]    rd_stb_o
);
  localparam int N_REG = N_RW + N_RO;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t r_wstate, w_wnext;
  r_state_t r_rstate, w_rnext;

  logic [N_RW*32-1:0] r_ctrl;
  logic [N_RW-1:0]    r_wr_stb;
  logic [N_REG-1:0]   r_rd_stb;

  logic        r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [1:0]  r_bresp;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;

  logic        r_arready, r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit;
  logic [31:0] w_waddr, w_wdata, w_woff;
  logic [3:0]  w_wstrb;
  logic [29:0] w_widx;
  logic        w_w_in_range, w_w_is_rw;

  logic        w_ar_hs;
  logic [31:0] w_roff, w_rd_data;
  logic [29:0] w_ridx;
  logic        w_r_in_range;
  logic        w_unused;

  // AW and W may arrive in either order; the live handshake value wins over the held copy
  assign w_aw_hs   = axi.awvalid & r_awready;
  assign w_w_hs    = axi.wvalid & r_wready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held | w_w_hs;
  assign w_commit  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;
  assign w_waddr   = w_aw_hs ? axi.awaddr : r_awaddr;
  assign w_wdata   = w_w_hs ? axi.wdata : r_wdata;
  assign w_wstrb   = w_w_hs ? axi.wstrb : r_wstrb;
  assign w_woff    = w_waddr - BASE_ADDR;
  assign w_widx    = w_woff[31:2];
  assign w_w_in_range = w_widx < 30'(N_REG);
  assign w_w_is_rw    = w_widx < 30'(N_RW);

  assign w_ar_hs   = (r_rstate == R_IDLE) & axi.arvalid & r_arready;
  assign w_roff    = axi.araddr - BASE_ADDR;
  assign w_ridx    = w_roff[31:2];
  assign w_r_in_range = w_ridx < 30'(N_REG);

  assign w_unused  = ^{w_woff[1:0], w_roff[1:0], axi.awprot, axi.arprot};

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wnext = W_RESP;
      W_RESP:  if (axi.bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (axi.rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read mux sees r_ctrl before any same-edge write commit lands
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < N_RW; k++)
      if (w_ridx == 30'(k)) w_rd_data = r_ctrl[k*32 +: 32];
    for (int k = 0; k < N_RO; k++)
      if (w_ridx == 30'(N_RW + k)) w_rd_data = status_i[k*32 +: 32];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ctrl    <= RW_RESET;
      r_wr_stb  <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wr_stb <= '0;
      if (r_wstate == W_IDLE) begin
        r_awready <= !w_aw_have;
        r_wready  <= !w_w_have;
        r_aw_held <= w_aw_have & !w_commit;
        r_w_held  <= w_w_have & !w_commit;
        if (w_aw_hs) r_awaddr <= axi.awaddr;
        if (w_w_hs) begin
          r_wdata <= axi.wdata;
          r_wstrb <= axi.wstrb;
        end
        if (w_commit) begin
          r_bvalid <= 1'b1;
          if (!w_w_in_range) begin
            r_bresp <= 2'b11;
          end else if (!w_w_is_rw) begin
            r_bresp <= 2'b10;
          end else begin
            r_bresp <= 2'b00;
            for (int k = 0; k < N_RW; k++) begin
              if (w_widx == 30'(k)) begin
                r_wr_stb[k] <= 1'b1;
                for (int b = 0; b < 4; b++)
                  if (w_wstrb[b]) r_ctrl[k*32 + b*8 +: 8] <= w_wdata[b*8 +: 8];
              end
            end
          end
        end
      end else if (axi.bready) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_rd_stb  <= '0;
    end else begin
      r_rd_stb  <= '0;
      r_arready <= (w_rnext == R_IDLE);
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_r_in_range ? 2'b00 : 2'b11;
        for (int k = 0; k < N_REG; k++)
          if (w_ridx == 30'(k)) r_rd_stb[k] <= 1'b1;
      end else if (r_rvalid && axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;
  assign ctrl_o      = r_ctrl;
  assign wr_stb_o    = r_wr_stb;
  assign rd_stb_o    = r_rd_stb;
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - directed bench for axi_lite_regfile
module tb_axi_lite_regfile;
  localparam logic [255:0] RW_RST = {224'h0, 32'hA5A5_0001};

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [255:0] ctrl_o;
  logic [255:0] status_i;
  logic [7:0]   wr_stb_o;
  logic [15:0]  rd_stb_o;
  logic [255:0] ctrl_exp;
  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  axi4_lite_if axi();

  axi_lite_regfile #(
    .BASE_ADDR(32'h0000_0000), .N_RW(8), .N_RO(8), .RW_RESET(RW_RST)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi), .ctrl_o(ctrl_o),
    .status_i(status_i), .wr_stb_o(wr_stb_o), .rd_stb_o(rd_stb_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic read_req(input logic [31:0] addr);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    for (int i = 0; i < 20 && axi.arready !== 1'b1; i++) @(negedge aclk);
    chk("ar_ready_wait", axi.arready, 1);
    @(negedge aclk);
    axi.arvalid = 1'b0;
  endtask

  task automatic write_req(input bit do_aw, input bit do_w, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    if (do_aw) begin
      axi.awaddr  = addr;
      axi.awvalid = 1'b1;
    end
    if (do_w) begin
      axi.wdata  = data;
      axi.wstrb  = strb;
      axi.wvalid = 1'b1;
    end
    for (int i = 0; i < 20 && !((!do_aw || axi.awready === 1'b1) && (!do_w || axi.wready === 1'b1)); i++)
      @(negedge aclk);
    chk("aw_w_ready_wait", {(!do_aw || axi.awready === 1'b1), (!do_w || axi.wready === 1'b1)}, 2'b11);
    @(negedge aclk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
  endtask

  task automatic b_ack;
    axi.bready = 1'b1;
    @(negedge aclk);
    axi.bready = 1'b0;
  endtask

  task automatic r_ack;
    axi.rready = 1'b1;
    @(negedge aclk);
    axi.rready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    status_i = '0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    cyc(3);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_bresp", axi.bresp, 0);
    chk("rst_rresp", axi.rresp, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_ctrl", ctrl_o, RW_RST);
    chk("rst_strobes", {wr_stb_o, rd_stb_o}, 0);

    aresetn = 1'b1;
    cyc(1);
    chk("post_rst_arready", axi.arready, 1);
    chk("post_rst_awready", axi.awready, 1);
    chk("post_rst_wready", axi.wready, 1);

    read_req(32'h0);
    chk("rd0_rvalid", axi.rvalid, 1);
    chk("rd0_rdata", axi.rdata, 32'hA5A5_0001);
    chk("rd0_rresp", axi.rresp, 0);
    chk("rd0_rd_stb", rd_stb_o, 16'h0001);
    chk("rd0_arready_low", axi.arready, 0);
    r_ack;
    chk("rd0_rvalid_clr", axi.rvalid, 0);
    chk("rd0_arready_back", axi.arready, 1);
    chk("rd0_rd_stb_clr", rd_stb_o, 0);

    write_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    chk("wr1_awready_low", axi.awready, 0);
    chk("wr1_wready_hold", axi.wready, 1);
    chk("wr1_no_bvalid", axi.bvalid, 0);
    cyc(2);
    chk("wr1_wready_still", axi.wready, 1);
    chk("wr1_ctrl_before", ctrl_o[63:32], 0);
    write_req(1'b0, 1'b1, 32'h0, 32'h1234_5678, 4'b0101);
    chk("wr1_ctrl", ctrl_o[63:32], 32'h0034_0078);
    chk("wr1_wr_stb", wr_stb_o, 8'h02);
    chk("wr1_bvalid", axi.bvalid, 1);
    chk("wr1_bresp", axi.bresp, 0);
    repeat (5) begin
      cyc(1);
      chk("wr1_hold_bvalid", axi.bvalid, 1);
      chk("wr1_hold_bresp", axi.bresp, 0);
      chk("wr1_hold_awready", axi.awready, 0);
      chk("wr1_hold_wr_stb", wr_stb_o, 0);
    end
    b_ack;
    chk("wr1_bvalid_clr", axi.bvalid, 0);
    chk("wr1_awready_back", axi.awready, 1);
    chk("wr1_wready_back", axi.wready, 1);
    ctrl_exp = {192'h0, 32'h0034_0078, 32'hA5A5_0001};

    status_i[31:0] = 32'hCAFE_F00D;
    read_req(32'h20);
    chk("ro_rdata", axi.rdata, 32'hCAFE_F00D);
    chk("ro_rresp", axi.rresp, 0);
    chk("ro_rd_stb", rd_stb_o, 16'h0100);
    status_i[31:0] = 32'h0;
    repeat (5) begin
      cyc(1);
      chk("ro_hold_rvalid", axi.rvalid, 1);
      chk("ro_hold_rdata", axi.rdata, 32'hCAFE_F00D);
      chk("ro_hold_rresp", axi.rresp, 0);
      chk("ro_hold_arready", axi.arready, 0);
    end
    r_ack;
    chk("ro_rvalid_clr", axi.rvalid, 0);
    chk("ro_arready_back", axi.arready, 1);
    write_req(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    chk("ro_wr_bresp", axi.bresp, 2'b10);
    chk("ro_wr_stb", wr_stb_o, 0);
    chk("ro_wr_ctrl", ctrl_o, ctrl_exp);
    b_ack;

    read_req(32'h40);
    chk("oor_rresp", axi.rresp, 2'b11);
    chk("oor_rdata", axi.rdata, 0);
    chk("oor_rd_stb", rd_stb_o, 0);
    r_ack;
    write_req(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
    chk("oor_wr_bresp", axi.bresp, 2'b11);
    chk("oor_wr_stb", wr_stb_o, 0);
    chk("oor_wr_ctrl", ctrl_o, ctrl_exp);
    b_ack;

    write_req(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0);
    chk("strb0_bresp", axi.bresp, 0);
    chk("strb0_wr_stb", wr_stb_o, 8'h04);
    chk("strb0_ctrl", ctrl_o, ctrl_exp);
    b_ack;

    axi.awaddr = 32'h2; axi.awvalid = 1'b1;
    axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = 32'h1; axi.arvalid = 1'b1;
    @(negedge aclk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("same_edge_rdata_old", axi.rdata, 32'hA5A5_0001);
    chk("same_edge_rd_stb", rd_stb_o, 16'h0001);
    chk("same_edge_ctrl", ctrl_o[31:0], 32'hDEAD_BEEF);
    chk("same_edge_wr_stb", wr_stb_o, 8'h01);
    chk("same_edge_valids", {axi.bvalid, axi.rvalid}, 2'b11);

    aresetn = 1'b0;
    cyc(1);
    chk("mid_rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    chk("mid_rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
    chk("mid_rst_ctrl", ctrl_o, RW_RST);
    chk("mid_rst_strobes", {wr_stb_o, rd_stb_o}, 0);
    aresetn = 1'b1;
    cyc(1);
    read_req(32'h0);
    chk("after_rst_rdata", axi.rdata, 32'hA5A5_0001);
    chk("after_rst_rresp", axi.rresp, 0);
    r_ack;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- AXI4-Lite slave register bank; the responder end of the AXI4-Lite master produced by the PCIe endpoint path.
- Maps host BAR accesses onto N_RW read/write control registers and N_RO read-only status registers.
- Generates per-register write and read strobes for downstream user logic.
- Sits on the `clk_out` domain, fed directly by the PCIe wrapper master (or by the simulation AXI model).

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- N_RW, 8, number of RW control registers (indices 0..N_RW-1).
- N_RO, 8, number of RO status registers (indices N_RW..N_RW+N_RO-1).
- RW_RESET, '0, packed N_RW*32 reset values for the control registers.

Ports:
- aclk  in  1  clock; connect to PCIe `clk_out`.
- aresetn  in  1  synchronous, active-low reset.
- axi  axi4_lite_if.s  -  32-bit address, 32-bit data, 4-bit wstrb AXI4-Lite slave.
- ctrl_o  out  N_RW*32  control register contents; register k is at bits [32k+31:32k].
- status_i  in  N_RO*32  status values, sampled at read time.
- wr_stb_o  out  N_RW  one-cycle pulse on bit k when control register k is written.
- rd_stb_o  out  N_RW+N_RO  one-cycle pulse on bit k when register k is read.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - awready, wready, arready, bvalid, rvalid = 0.
  - bresp, rresp = 2'b00; rdata = 0.
  - ctrl_o = RW_RESET; strobes = 0.
  - All FSMs return to IDLE. An in-flight transaction is dropped with no response.
  - Ready signals go to 1 on the first edge after aresetn=1.
- Address decode: off = addr - BASE_ADDR; idx = off[31:2]; addr[1:0] is ignored. idx >= N_RW+N_RO is out of range.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AW and W are captured independently. awready drops after the AW handshake and wready drops after the W handshake. Either order is accepted, as is the same cycle.
  - At the edge where both are held, the write commits and the FSM enters W_RESP with bvalid=1.
  - RW idx: byte lanes with wstrb=1 are updated, others unchanged. wr_stb_o[idx]=1 for exactly that next cycle. bresp=OKAY.
  - wstrb=0 gives OKAY, no change, and a strobe still pulses.
  - RO idx: no change, no strobe, bresp=SLVERR (2'b10).
  - Out of range: no change, bresp=DECERR (2'b11).
  - bvalid holds, and bresp stays stable, until bready. On the bready handshake: bvalid=0, awready=wready=1, back to W_IDLE.
  - Write latency: last of AW/W handshake at edge N → ctrl_o updated and bvalid=1 in cycle N+1.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE arready=1. On AR handshake at edge N:
    - rdata registered from ctrl_o or status_i (value as of that edge, i.e. before any write committing at the same edge).
    - rvalid=1 in cycle N+1; arready=0; rd_stb_o[idx] pulses in cycle N+1.
  - Out of range: rdata=32'h0, rresp=DECERR, no strobe. In range: rresp=OKAY.
  - rdata/rresp stay stable while rvalid && !rready.
  - On rready handshake: rvalid=0, arready=1 the next cycle. Sustained throughput is one read per 2 cycles.
- Concurrency:
  - Read and write FSMs are fully independent; no arbitration.
  - Read of an address written at the same edge returns the old value.
  - No outstanding-transaction depth beyond 1 per channel.
- awprot/arprot are ignored.

Test Plan:
- Reset with RW_RESET[0]=32'hA5A5_0001, then read 0x0 → rvalid one cycle after AR, rdata=32'hA5A5_0001, rresp=00; arready=1 on the first cycle after aresetn rises.
- AW to 0x4 at cycle 0, W data 32'h1234_5678 strb 4'b0101 at cycle 3 → wready stays 1 until cycle 3; ctrl_o[63:32]=32'h0034_0078 (from zero) and wr_stb_o[1]=1 at cycle 4; bvalid at cycle 4 with bresp=00.
- status_i reg 0 = 32'hCAFE_F00D, read BASE+N_RW*4=0x20 → rdata=32'hCAFE_F00D, OKAY, rd_stb_o[8] pulse; write to 0x20 → bresp=10, ctrl_o unchanged.
- Read 0x40 (idx 16) → rresp=11, rdata=0; write 0x40 → bresp=11, no strobe.
- Hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid and resp/data stable; awready/arready stay 0 until the handshake.
- Deassert aresetn while bvalid=1 and rvalid=1 → the next cycle all valids=0 and ctrl_o=RW_RESET; a subsequent read of 0x0 returns RW_RESET[0].
